// File: rtl/attr_interp_sequencer.sv
// attr_interp_sequencer: time-multiplexes one barycentric interpolator
// across all attributes of a fragment, one result per cycle.
module attr_interp_sequencer #(
   parameter int ATTR_WIDTH   = 32,
   parameter int WEIGHT_WIDTH = 21,
   parameter int NUM_ATTRS    = 4,
   parameter int TAG_WIDTH    = 16,
   localparam int IDX_W = (NUM_ATTRS > 1) ? $clog2(NUM_ATTRS) : 1
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_frag_valid,
   output logic                          o_frag_ready,
   input  logic [WEIGHT_WIDTH-1:0]       i_lambda0,
   input  logic [WEIGHT_WIDTH-1:0]       i_lambda1,
   input  logic [WEIGHT_WIDTH-1:0]       i_lambda2,
   input  logic [NUM_ATTRS*ATTR_WIDTH-1:0] i_attrs0,
   input  logic [NUM_ATTRS*ATTR_WIDTH-1:0] i_attrs1,
   input  logic [NUM_ATTRS*ATTR_WIDTH-1:0] i_attrs2,
   input  logic [TAG_WIDTH-1:0]          i_frag_tag,
   output logic                          o_attr_valid,
   input  logic                          i_attr_ready,
   output logic [ATTR_WIDTH-1:0]         o_attr_value,
   output logic [IDX_W-1:0]              o_attr_idx,
   output logic                          o_attr_last,
   output logic [TAG_WIDTH-1:0]          o_attr_tag,
   output logic                          o_busy
);

   // Bits above ATTR_WIDTH+WEIGHT_WIDTH never reach the truncated
   // result, so products are kept only to that width.
   localparam int PW = ATTR_WIDTH + WEIGHT_WIDTH;
   localparam int VW = NUM_ATTRS * ATTR_WIDTH;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ATTRS - 1);

   typedef enum logic {
      S_IDLE,
      S_RUN
   } state_t;

   state_t                  r_state;
   logic [IDX_W-1:0]        r_cnt;
   logic [WEIGHT_WIDTH-1:0] r_l0;
   logic [WEIGHT_WIDTH-1:0] r_l1;
   logic [WEIGHT_WIDTH-1:0] r_l2;
   logic [VW-1:0]           r_a0;
   logic [VW-1:0]           r_a1;
   logic [VW-1:0]           r_a2;
   logic [TAG_WIDTH-1:0]    r_tag;
   logic                    r_valid;
   logic [ATTR_WIDTH-1:0]   r_value;
   logic [IDX_W-1:0]        r_idx;
   logic                    r_last;
   logic [TAG_WIDTH-1:0]    r_otag;

   logic [ATTR_WIDTH-1:0]   w_v0 [NUM_ATTRS];
   logic [ATTR_WIDTH-1:0]   w_v1 [NUM_ATTRS];
   logic [ATTR_WIDTH-1:0]   w_v2 [NUM_ATTRS];
   logic signed [ATTR_WIDTH-1:0]   w_a0;
   logic signed [ATTR_WIDTH-1:0]   w_a1;
   logic signed [ATTR_WIDTH-1:0]   w_a2;
   logic signed [WEIGHT_WIDTH-1:0] w_l0;
   logic signed [WEIGHT_WIDTH-1:0] w_l1;
   logic signed [WEIGHT_WIDTH-1:0] w_l2;
   logic signed [PW-1:0]    w_p0;
   logic signed [PW-1:0]    w_p1;
   logic signed [PW-1:0]    w_p2;
   logic signed [PW-1:0]    w_sum;
   logic [ATTR_WIDTH-1:0]   w_res;
   logic                    w_load;
   logic                    w_last;

   for (genvar g = 0; g < NUM_ATTRS; g++) begin : g_unpack
      assign w_v0[g] = r_a0[g*ATTR_WIDTH +: ATTR_WIDTH];
      assign w_v1[g] = r_a1[g*ATTR_WIDTH +: ATTR_WIDTH];
      assign w_v2[g] = r_a2[g*ATTR_WIDTH +: ATTR_WIDTH];
   end

   assign w_a0 = w_v0[r_cnt];
   assign w_a1 = w_v1[r_cnt];
   assign w_a2 = w_v2[r_cnt];
   assign w_l0 = r_l0;
   assign w_l1 = r_l1;
   assign w_l2 = r_l2;

   assign w_p0  = PW'(w_a0) * PW'(w_l0);
   assign w_p1  = PW'(w_a1) * PW'(w_l1);
   assign w_p2  = PW'(w_a2) * PW'(w_l2);
   assign w_sum = w_p0 + w_p1 + w_p2;
   // Taking bits above the weight fraction is the flooring shift.
   assign w_res = w_sum[WEIGHT_WIDTH +: ATTR_WIDTH];

   assign w_load = (r_state == S_RUN) && (!r_valid || i_attr_ready);
   assign w_last = (r_cnt == LAST_IDX);

   assign o_frag_ready = (r_state == S_IDLE);
   assign o_busy       = (r_state == S_RUN) || r_valid;
   assign o_attr_valid = r_valid;
   assign o_attr_value = r_value;
   assign o_attr_idx   = r_idx;
   assign o_attr_last  = r_last;
   assign o_attr_tag   = r_otag;

   // Fragment capture, attribute stepping and single-entry output register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_l0    <= '0;
         r_l1    <= '0;
         r_l2    <= '0;
         r_a0    <= '0;
         r_a1    <= '0;
         r_a2    <= '0;
         r_tag   <= '0;
         r_valid <= 1'b0;
         r_value <= '0;
         r_idx   <= '0;
         r_last  <= 1'b0;
         r_otag  <= '0;
      end else begin
         if (w_load) begin
            r_valid <= 1'b1;
            r_value <= w_res;
            r_idx   <= r_cnt;
            r_last  <= w_last;
            r_otag  <= r_tag;
         end else if (i_attr_ready && r_valid) begin
            r_valid <= 1'b0;
         end
         unique case (r_state)
            S_IDLE: begin
               if (i_frag_valid) begin
                  r_l0    <= i_lambda0;
                  r_l1    <= i_lambda1;
                  r_l2    <= i_lambda2;
                  r_a0    <= i_attrs0;
                  r_a1    <= i_attrs1;
                  r_a2    <= i_attrs2;
                  r_tag   <= i_frag_tag;
                  r_cnt   <= '0;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               if (w_load) begin
                  if (w_last) r_state <= S_IDLE;
                  else        r_cnt   <= r_cnt + 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_attr_interp_sequencer.sv
// tb_attr_interp_sequencer: directed stimulus against a queue-based
// arithmetic model, plus literal expectations on selected results.
module tb_attr_interp_sequencer;

   localparam int AW = 32;
   localparam int WW = 21;
   localparam int NA = 4;
   localparam int TW = 16;
   localparam int IW = 2;
   localparam int VW = NA * AW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_frag_valid;
   logic          o_frag_ready;
   logic [WW-1:0] i_lambda0, i_lambda1, i_lambda2;
   logic [VW-1:0] i_attrs0, i_attrs1, i_attrs2;
   logic [TW-1:0] i_frag_tag;
   logic          o_attr_valid;
   logic          i_attr_ready;
   logic [AW-1:0] o_attr_value;
   logic [IW-1:0] o_attr_idx;
   logic          o_attr_last;
   logic [TW-1:0] o_attr_tag;
   logic          o_busy;

   attr_interp_sequencer dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_frag_valid (i_frag_valid),
      .o_frag_ready (o_frag_ready),
      .i_lambda0    (i_lambda0),
      .i_lambda1    (i_lambda1),
      .i_lambda2    (i_lambda2),
      .i_attrs0     (i_attrs0),
      .i_attrs1     (i_attrs1),
      .i_attrs2     (i_attrs2),
      .i_frag_tag   (i_frag_tag),
      .o_attr_valid (o_attr_valid),
      .i_attr_ready (i_attr_ready),
      .o_attr_value (o_attr_value),
      .o_attr_idx   (o_attr_idx),
      .o_attr_last  (o_attr_last),
      .o_attr_tag   (o_attr_tag),
      .o_busy       (o_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] v;
      logic [IW-1:0] idx;
      logic          last;
      logic [TW-1:0] tag;
   } exp_t;

   exp_t q[$];
   int   errs = 0;
   int   checks = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errs++;
         $display("FAIL %s: got %0h required %0h at %0t", nm, act, req, $time);
      end
   endtask

   function automatic logic [VW-1:0] pk(input int v0, input int v1,
                                        input int v2, input int v3);
      return {32'(v3), 32'(v2), 32'(v1), 32'(v0)};
   endfunction

   // Interpolated value: weighted sum, floor-divide by 2^WW, keep low AW bits.
   function automatic logic [AW-1:0] mval(input logic [VW-1:0] a0, a1, a2,
                                          input logic [WW-1:0] l0, l1, l2,
                                          input int k);
      longint s;
      longint r;
      s = longint'($signed(a0[k*AW +: AW])) * longint'($signed(l0))
        + longint'($signed(a1[k*AW +: AW])) * longint'($signed(l1))
        + longint'($signed(a2[k*AW +: AW])) * longint'($signed(l2));
      r = s >>> WW;
      return r[AW-1:0];
   endfunction

   task automatic send(input logic [WW-1:0] l0, l1, l2,
                       input logic [VW-1:0] a0, a1, a2,
                       input logic [TW-1:0] tag, output int n);
      exp_t e;
      @(posedge clk); #1;
      i_lambda0 = l0; i_lambda1 = l1; i_lambda2 = l2;
      i_attrs0 = a0; i_attrs1 = a1; i_attrs2 = a2;
      i_frag_tag = tag;
      i_frag_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!o_frag_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!o_frag_ready) begin
         chk("accept_timeout", 0, 1);
         i_frag_valid = 1'b0;
         return;
      end
      for (int k = 0; k < NA; k++) begin
         e.v    = mval(a0, a1, a2, l0, l1, l2, k);
         e.idx  = IW'(k);
         e.last = (k == NA - 1);
         e.tag  = tag;
         q.push_back(e);
      end
      @(posedge clk); #1;
      i_frag_valid = 1'b0;
      i_lambda0 = WW'($urandom); i_lambda1 = WW'($urandom);
      i_lambda2 = WW'($urandom);
      i_attrs0 = {$urandom, $urandom, $urandom, $urandom};
      i_attrs1 = {$urandom, $urandom, $urandom, $urandom};
      i_attrs2 = {$urandom, $urandom, $urandom, $urandom};
      i_frag_tag = TW'($urandom);
   endtask

   task automatic wait_out(input int k);
      int n = 0;
      @(negedge clk);
      while (!(o_attr_valid && o_attr_idx == IW'(k)) && n < 100) begin
         n++;
         @(negedge clk);
      end
      if (n >= 100) chk("wait_idx_timeout", 0, 1);
   endtask

   task automatic drain();
      int n = 0;
      i_attr_ready = 1'b1;
      while ((q.size() != 0 || o_attr_valid) && n < 200) begin
         n++;
         @(negedge clk);
      end
      chk("drain_queue_empty", q.size(), 0);
      chk("drain_busy", o_busy, 0);
   endtask

   task automatic first_val(input string nm, input logic [31:0] req);
      @(negedge clk);
      @(negedge clk);
      chk({nm, "_valid"}, o_attr_valid, 1);
      chk({nm, "_idx"}, o_attr_idx, 0);
      chk({nm, "_value"}, o_attr_value, req);
   endtask

   // Compare every presented output against the model queue.
   initial begin : compare
      logic          hold;
      logic [AW-1:0] s_v;
      logic [IW-1:0] s_i;
      logic          s_l;
      logic [TW-1:0] s_t;
      hold = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            q.delete();
            hold = 1'b0;
         end else if (o_attr_valid) begin
            if (q.size() == 0) begin
               chk("spurious_valid", 1, 0);
            end else begin
               chk("m_value", o_attr_value, q[0].v);
               chk("m_idx", o_attr_idx, q[0].idx);
               chk("m_last", o_attr_last, q[0].last);
               chk("m_tag", o_attr_tag, q[0].tag);
            end
            if (hold) begin
               chk("hold_value", o_attr_value, s_v);
               chk("hold_idx", o_attr_idx, s_i);
               chk("hold_last", o_attr_last, s_l);
               chk("hold_tag", o_attr_tag, s_t);
            end
            hold = !i_attr_ready;
            s_v = o_attr_value; s_i = o_attr_idx;
            s_l = o_attr_last;  s_t = o_attr_tag;
            if (i_attr_ready && q.size() > 0) void'(q.pop_front());
         end else begin
            if (hold) chk("valid_dropped_under_stall", 0, 1);
            hold = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin : main
      int n;
      rst_n = 1'b0;
      i_frag_valid = 1'b0;
      i_attr_ready = 1'b1;
      i_lambda0 = '0; i_lambda1 = '0; i_lambda2 = '0;
      i_attrs0 = '0; i_attrs1 = '0; i_attrs2 = '0;
      i_frag_tag = '0;
      repeat (3) @(negedge clk);
      chk("rst_frag_ready", o_frag_ready, 1);
      chk("rst_valid", o_attr_valid, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_value", o_attr_value, 0);
      chk("rst_idx", o_attr_idx, 0);
      chk("rst_last", o_attr_last, 0);
      chk("rst_tag", o_attr_tag, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Latency, ordering, last flag; equal weights of 1/8 each.
      send(21'h40000, 21'h40000, 21'h40000,
           pk(400, 10, -300, 123456), pk(800, 20, 5000, -98765),
           pk(1200, 30, -7, 1), 16'h1234, n);
      @(negedge clk);
      chk("lat_e0_valid", o_attr_valid, 0);
      chk("lat_e0_frag_ready", o_frag_ready, 0);
      chk("lat_e0_busy", o_busy, 1);
      @(negedge clk);
      chk("lat_e1_valid", o_attr_valid, 1);
      chk("lat_e1_value", o_attr_value, 300);
      chk("lat_e1_idx", o_attr_idx, 0);
      chk("lat_e1_last", o_attr_last, 0);
      chk("lat_e1_tag", o_attr_tag, 16'h1234);
      @(negedge clk);
      chk("f1_idx1_value", o_attr_value, 7);
      chk("f1_idx1_frag_ready", o_frag_ready, 0);
      @(negedge clk);
      chk("f1_idx2_frag_ready", o_frag_ready, 0);
      @(negedge clk);
      chk("f1_idx3_idx", o_attr_idx, 3);
      chk("f1_idx3_last", o_attr_last, 1);
      chk("f1_idx3_frag_ready", o_frag_ready, 1);
      drain();

      // Sign and floor behaviour.
      send(21'h40000, 21'h0, 21'h0,
           pk(-1000, -8, -9, 32'h7FFFFFFF), pk(0, 0, 0, 0), pk(0, 0, 0, 0),
           16'h0002, n);
      first_val("neg_half", -125);
      drain();
      send(21'h1, 21'h0, 21'h0,
           pk(-1, 1, -2097153, 5), pk(0, 0, 0, 0), pk(0, 0, 0, 0),
           16'h0003, n);
      first_val("floor_m1", -1);
      @(negedge clk);
      chk("floor_p1_value", o_attr_value, 0);
      @(negedge clk);
      chk("floor_big_value", o_attr_value, -2);
      drain();

      // Wide values: wraps past ATTR_WIDTH, negative weights.
      send(21'h0FFFFF, 21'h0FFFFF, 21'h0FFFFF,
           pk(32'h7FFFFFFF, 32'h80000000, 123, -5),
           pk(32'h7FFFFFFF, 32'h80000000, -77, 9),
           pk(32'h7FFFFFFF, 32'h80000000, 1, 33), 16'hBEEF, n);
      send(21'h100000, 21'h1FFFFF, 21'h0ABCDE,
           pk(32'h12345678, -1, 32'h7FFFFFFF, 32'h80000000),
           pk(-5, 32'h0FFFFFFF, 1, 2),
           pk(99999, 7, -3, 32'h80000000), 16'hCAFE, n);
      drain();

      // Backpressure: freeze at idx 1 for 5 cycles.
      send(21'h20000, 21'h60000, 21'h80000,
           pk(11, 22, 33, 44), pk(-55, 66, -77, 88), pk(99, -111, 122, 133),
           16'h0055, n);
      wait_out(0);
      @(posedge clk); #1;
      i_attr_ready = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("bp_valid", o_attr_valid, 1);
         chk("bp_idx", o_attr_idx, 1);
      end
      @(posedge clk); #1;
      i_attr_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("bp_resume_idx", o_attr_idx, 2);
      drain();

      // Back-to-back fragments with tags A then B.
      send(21'h40000, 21'h20000, 21'h10000,
           pk(1, 2, 3, 4), pk(5, 6, 7, 8), pk(9, 10, 11, 12), 16'h000A, n);
      send(21'h50000, 21'h30000, 21'h1F0000,
           pk(-1, -2, -3, -4), pk(500, 600, 700, 800), pk(0, 1, 2, 3),
           16'h000B, n);
      chk("b2b_ready_low_cycles", n, 3);
      drain();

      // Asynchronous reset while idx 2 is stalled.
      send(21'h40000, 21'h40000, 21'h40000,
           pk(8, 16, 24, 32), pk(8, 16, 24, 32), pk(8, 16, 24, 32),
           16'h0077, n);
      wait_out(1);
      @(posedge clk); #1;
      i_attr_ready = 1'b0;
      @(negedge clk);
      chk("rst_pre_idx", o_attr_idx, 2);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", o_attr_valid, 0);
      chk("arst_frag_ready", o_frag_ready, 1);
      chk("arst_busy", o_busy, 0);
      repeat (2) @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      i_attr_ready = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("post_rst_no_output", o_attr_valid, 0);
      end
      send(21'h40000, 21'h0, 21'h0,
           pk(-1000, 3, 5, 7), pk(1, 1, 1, 1), pk(2, 2, 2, 2),
           16'h0099, n);
      first_val("post_rst", -125);
      drain();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
